// File: rtl/algo_t1_bank_resp_pkg.sv
// algo_t1_bank_resp_pkg
//   Shared definitions for the t1 single-bank responder:
//   - error-code positions in the responder's error vector
//   - legal SRAM_DELAY range
//   - sub-bank extraction from a row address
package algo_t1_bank_resp_pkg;

  // Position of each error flag in the responder's error vector.
  typedef enum logic [1:0] {
    ERR_RW   = 2'd0,  // read and write strobes in the same cycle
    ERR_COLL = 2'd1,  // access hits the sub-bank being refreshed
    ERR_OOR  = 2'd2,  // row address beyond the macro depth
    ERR_NREF = 2'd3   // refresh starvation (sticky)
  } err_code_e;

  localparam int NUM_ERR = 4;

  // Read latency limits of the modelled macro.
  localparam int SRAM_DELAY_MIN = 1;
  localparam int SRAM_DELAY_MAX = 8;

  // Refresh sub-bank addressed by a row: the low 'bits' address bits.
  function automatic logic [7:0] sub_bank(input logic [31:0] addr, input int bits);
    logic [31:0] mask;
    mask = (32'd1 << bits) - 32'd1;
    return 8'(addr & mask);
  endfunction

endpackage

// File: rtl/algo_t1_rd_pipe.sv
// algo_t1_rd_pipe
//   DEPTH-stage {vld,data} shift pipeline carrying read data from the array
//   to the responder output. Stage 0 samples the array, the last stage drives
//   the output. Only the valid bits are reset; a data stage loads only when
//   its incoming valid is set, so the last stage keeps the last valid word.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_vld/in_data  read launch (in_vld=0 for a dropped read)
//   out_vld/out_data  pipeline output
module algo_t1_rd_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic             vld_reg  [DEPTH];
  logic [WIDTH-1:0] data_reg [DEPTH];
  logic             vld_in   [DEPTH];
  logic [WIDTH-1:0] data_in  [DEPTH];

  // Stage inputs: stage 0 from the launch port, others from the previous stage.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage_in
      if (gi == 0) begin : g_first
        assign vld_in[gi]  = in_vld;
        assign data_in[gi] = in_data;
      end else begin : g_next
        assign vld_in[gi]  = vld_reg[gi-1];
        assign data_in[gi] = data_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) vld_reg[i] <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) vld_reg[i] <= vld_in[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_in[i]) data_reg[i] <= data_in[i];
    end
  end

  assign out_vld  = vld_reg[DEPTH-1];
  assign out_data = data_reg[DEPTH-1];

endmodule

// File: rtl/algo_t1_bank_resp.sv
// algo_t1_bank_resp
//   Memory-side responder for one t1 virtual bank: a PHYWDTH x NUMSROW SRAM
//   model with SRAM_DELAY read latency, per-bit write mask, per-sub-bank
//   refresh and protocol checking.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   t1_readA/t1_writeA       access strobes
//   t1_addrA                 row address (low BITRBNK bits = sub-bank)
//   t1_dinA/t1_bwA           write data and per-bit write enable
//   t1_dwsnA                 dwsn tuning value, captured into dwsn_q
//   t1_doutA/t1_vldA         read data (held when not valid) and valid
//   t1_refrB/t1_bankB        refresh strobe and sub-bank
//   dwsn_q                   last captured dwsn value
//   err_rw/err_coll/err_oor  one-cycle error pulses
//   err_nref                 sticky refresh-starvation flag
module algo_t1_bank_resp
  import algo_t1_bank_resp_pkg::*;
#(
  parameter int NUMSROW    = 4096,
  parameter int BITSROW    = 12,
  parameter int PHYWDTH    = 128,
  parameter int SRAM_DELAY = 2,
  parameter int NUMRBNK    = 2,
  parameter int BITRBNK    = 1,
  parameter int BITDWSN    = 8,
  parameter int REFMAX     = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               t1_readA,
  input  logic               t1_writeA,
  input  logic [BITSROW-1:0] t1_addrA,
  input  logic [PHYWDTH-1:0] t1_dinA,
  input  logic [PHYWDTH-1:0] t1_bwA,
  input  logic [BITDWSN-1:0] t1_dwsnA,
  output logic [PHYWDTH-1:0] t1_doutA,
  output logic               t1_vldA,
  input  logic               t1_refrB,
  input  logic [BITRBNK-1:0] t1_bankB,
  output logic [BITDWSN-1:0] dwsn_q,
  output logic               err_rw,
  output logic               err_coll,
  output logic               err_oor,
  output logic               err_nref
);

  // Latency outside the macro's legal range is clamped to the nearest limit.
  localparam int PIPE_DEPTH = (SRAM_DELAY < SRAM_DELAY_MIN) ? SRAM_DELAY_MIN :
                              (SRAM_DELAY > SRAM_DELAY_MAX) ? SRAM_DELAY_MAX : SRAM_DELAY;
  localparam int CNT_W = (REFMAX > 0) ? $clog2(REFMAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFMAX);

  // ---------------------------------------------------------------- classify
  logic               access;
  logic               rd_wr;
  logic               bank_valid;
  logic               coll;
  logic               in_range;
  logic               oor;
  logic               rd_ok;
  logic               wr_ok;
  logic [BITSROW-1:0] row_idx;

  assign access     = t1_readA | t1_writeA;
  assign rd_wr      = t1_readA & t1_writeA;
  assign bank_valid = (32'(t1_bankB) < 32'(NUMRBNK));
  assign coll       = !rd_wr && access && t1_refrB && bank_valid &&
                      (sub_bank(32'(t1_addrA), BITRBNK) == 8'(t1_bankB));
  assign in_range   = (32'(t1_addrA) < 32'(NUMSROW));
  assign oor        = !rd_wr && !coll && access && !in_range;
  assign rd_ok      = t1_readA  && !t1_writeA && !coll && in_range;
  assign wr_ok      = t1_writeA && !t1_readA  && !coll && in_range;
  // Keeps the array read in bounds when a dropped out-of-range read launches.
  assign row_idx    = in_range ? t1_addrA : '0;

  // ---------------------------------------------------------------- array
  logic [PHYWDTH-1:0] mem [NUMSROW];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[row_idx] <= (mem[row_idx] & ~t1_bwA) | (t1_dinA & t1_bwA);
  end

  // Stage 0 of the pipe is the registered array read. Every read strobe
  // launches a slot; a dropped read carries vld=0 so its latency slot is empty.
  logic               pipe_vld;
  logic [PHYWDTH-1:0] pipe_data;

  algo_t1_rd_pipe #(
    .DEPTH (PIPE_DEPTH),
    .WIDTH (PHYWDTH)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_ok),
    .in_data  (mem[row_idx]),
    .out_vld  (pipe_vld),
    .out_data (pipe_data)
  );

  // Pipe data is not reset, so a resettable copy supplies the held value.
  logic [PHYWDTH-1:0] dout_hold_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_hold_reg <= '0;
    end else if (pipe_vld) begin
      dout_hold_reg <= pipe_data;
    end
  end

  assign t1_vldA  = pipe_vld;
  assign t1_doutA = pipe_vld ? pipe_data : dout_hold_reg;

  // ---------------------------------------------------------------- refresh
  logic [CNT_W-1:0] refr_cnt_reg;
  logic [CNT_W-1:0] refr_cnt_next;
  logic             starve_hit;

  always_comb begin
    refr_cnt_next = refr_cnt_reg;
    if (t1_refrB) begin
      refr_cnt_next = '0;
    end else if (refr_cnt_reg != CNT_MAX) begin
      refr_cnt_next = refr_cnt_reg + 1'b1;
    end
  end

  // Starvation is flagged on the edge where the counter reaches REFMAX; a
  // refresh in that same cycle clears the counter instead.
  assign starve_hit = (REFMAX > 0) && !t1_refrB && (int'(refr_cnt_reg) >= REFMAX - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) refr_cnt_reg <= '0;
    else     refr_cnt_reg <= refr_cnt_next;
  end

  // ---------------------------------------------------------------- errors
  logic [NUM_ERR-1:0] err_reg;
  logic [NUM_ERR-1:0] err_next;

  always_comb begin
    err_next           = '0;
    err_next[ERR_RW]   = rd_wr;
    err_next[ERR_COLL] = coll;
    err_next[ERR_OOR]  = oor;
    err_next[ERR_NREF] = err_reg[ERR_NREF] | starve_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_reg <= '0;
    else     err_reg <= err_next;
  end

  assign err_rw   = err_reg[ERR_RW];
  assign err_coll = err_reg[ERR_COLL];
  assign err_oor  = err_reg[ERR_OOR];
  assign err_nref = err_reg[ERR_NREF];

  // ---------------------------------------------------------------- dwsn
  logic [BITDWSN-1:0] dwsn_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dwsn_reg <= '0;
    else if (access) dwsn_reg <= t1_dwsnA;
  end

  assign dwsn_q = dwsn_reg;

endmodule
